// File: rtl/traffic_junction.sv
// -----------------------------------------------------------------------------
// traffic_junction
//
// Two-road junction controller. Sequences the north-south (NS) and east-west
// (EW) signal heads through red -> red+amber -> green -> amber -> red, with an
// all-red clearance interval before each road's red+amber. A pedestrian request
// is latched and served as an all-red WALK phase after the next amber phase
// ends. A fault request overrides everything and flashes amber on both heads.
// All phase durations are counted in clk cycles.
//
// Parameters
//   GREEN_CYCLES     green duration per road
//   AMBER_CYCLES     amber duration per road
//   RED_AMBER_CYCLES red+amber duration per road
//   ALL_RED_CYCLES   all-red clearance before each road's red+amber
//   WALK_CYCLES      pedestrian walk duration
//   FLASH_CYCLES     half-period of the fault-mode amber flash
//   CNT_W            phase counter width (every *_CYCLES is 1 .. 2**CNT_W)
//
// Ports
//   clk_i          system clock, all state changes on the rising edge
//   reset_i        asynchronous active-high reset
//   ped_req_i      pedestrian request (level or pulse), sampled on clk_i
//   fault_i        fault-mode request (level), sampled on clk_i
//   ns_lamp_o      NS head lamps {red, amber, green}
//   ew_lamp_o      EW head lamps {red, amber, green}
//   ped_walk_o     walk indication, high only during the WALK phase
//   ped_pending_o  pedestrian request latched but not yet served
// -----------------------------------------------------------------------------
module traffic_junction #(
    parameter int unsigned GREEN_CYCLES     = 8,
    parameter int unsigned AMBER_CYCLES     = 3,
    parameter int unsigned RED_AMBER_CYCLES = 2,
    parameter int unsigned ALL_RED_CYCLES   = 2,
    parameter int unsigned WALK_CYCLES      = 6,
    parameter int unsigned FLASH_CYCLES     = 4,
    parameter int unsigned CNT_W            = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ped_req_i,
    input  logic       fault_i,
    output logic [2:0] ns_lamp_o,
    output logic [2:0] ew_lamp_o,
    output logic       ped_walk_o,
    output logic       ped_pending_o
);

    // Lamp encodings, {red, amber, green}
    localparam logic [2:0] LAMP_RED       = 3'b100;
    localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
    localparam logic [2:0] LAMP_GREEN     = 3'b001;
    localparam logic [2:0] LAMP_AMBER     = 3'b010;
    localparam logic [2:0] LAMP_OFF       = 3'b000;

    // Counter reload values: a phase of P cycles loads P-1 on entry and
    // leaves on the edge where the counter reads zero.
    localparam logic [CNT_W-1:0] GREEN_LD     = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] AMBER_LD     = CNT_W'(AMBER_CYCLES - 1);
    localparam logic [CNT_W-1:0] RED_AMBER_LD = CNT_W'(RED_AMBER_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALL_RED_LD   = CNT_W'(ALL_RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_LD      = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LD     = CNT_W'(FLASH_CYCLES - 1);

    typedef enum logic [3:0] {
        AR_NS = 4'd0,
        NS_RA = 4'd1,
        NS_G  = 4'd2,
        NS_A  = 4'd3,
        AR_EW = 4'd4,
        EW_RA = 4'd5,
        EW_G  = 4'd6,
        EW_A  = 4'd7,
        WALK  = 4'd8,
        FLASH = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             flash_q, flash_d;
    // Where WALK hands over to: 1 -> AR_EW (walk followed NS amber),
    // 0 -> AR_NS (walk followed EW amber).
    logic             walk_to_ew_q, walk_to_ew_d;

    logic             expired;

    assign expired = (cnt_q == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= AR_NS;
            cnt_q        <= ALL_RED_LD;
            pending_q    <= 1'b0;
            flash_q      <= 1'b1;
            walk_to_ew_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            flash_q      <= flash_d;
            walk_to_ew_q <= walk_to_ew_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        flash_d      = flash_q;
        walk_to_ew_d = walk_to_ew_q;

        if (fault_i) begin
            // Fault overrides phase expiry and any pedestrian request.
            state_d   = FLASH;
            pending_d = 1'b0;
            if (state_q != FLASH) begin
                // Fresh entry: flash starts lit with a full half-period.
                cnt_d   = FLASH_LD;
                flash_d = 1'b1;
            end else if (expired) begin
                cnt_d   = FLASH_LD;
                flash_d = ~flash_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            // Requests are only latched in the normal cycle; WALK and FLASH
            // ignore them.
            if (ped_req_i && (state_q != WALK) && (state_q != FLASH)) begin
                pending_d = 1'b1;
            end

            if (!expired) begin
                cnt_d = cnt_q - 1'b1;
            end

            case (state_q)
                AR_NS: if (expired) begin
                    state_d = NS_RA;
                    cnt_d   = RED_AMBER_LD;
                end
                NS_RA: if (expired) begin
                    state_d = NS_G;
                    cnt_d   = GREEN_LD;
                end
                NS_G: if (expired) begin
                    state_d = NS_A;
                    cnt_d   = AMBER_LD;
                end
                NS_A: if (expired) begin
                    // Only a request latched before this edge is served here;
                    // one arriving on this edge waits for the next amber.
                    if (pending_q) begin
                        state_d      = WALK;
                        cnt_d        = WALK_LD;
                        pending_d    = 1'b0;
                        walk_to_ew_d = 1'b1;
                    end else begin
                        state_d = AR_EW;
                        cnt_d   = ALL_RED_LD;
                    end
                end
                AR_EW: if (expired) begin
                    state_d = EW_RA;
                    cnt_d   = RED_AMBER_LD;
                end
                EW_RA: if (expired) begin
                    state_d = EW_G;
                    cnt_d   = GREEN_LD;
                end
                EW_G: if (expired) begin
                    state_d = EW_A;
                    cnt_d   = AMBER_LD;
                end
                EW_A: if (expired) begin
                    if (pending_q) begin
                        state_d      = WALK;
                        cnt_d        = WALK_LD;
                        pending_d    = 1'b0;
                        walk_to_ew_d = 1'b0;
                    end else begin
                        state_d = AR_NS;
                        cnt_d   = ALL_RED_LD;
                    end
                end
                WALK: if (expired) begin
                    state_d = walk_to_ew_q ? AR_EW : AR_NS;
                    cnt_d   = ALL_RED_LD;
                end
                FLASH: begin
                    // Fault released: restart with a full NS clearance.
                    state_d = AR_NS;
                    cnt_d   = ALL_RED_LD;
                    flash_d = 1'b1;
                end
                default: begin
                    // Unreachable encodings recover to a safe all-red start.
                    state_d = AR_NS;
                    cnt_d   = ALL_RED_LD;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (Moore, registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        ns_lamp_o  = LAMP_RED;
        ew_lamp_o  = LAMP_RED;
        ped_walk_o = 1'b0;

        case (state_q)
            NS_RA: ns_lamp_o = LAMP_RED_AMBER;
            NS_G:  ns_lamp_o = LAMP_GREEN;
            NS_A:  ns_lamp_o = LAMP_AMBER;
            EW_RA: ew_lamp_o = LAMP_RED_AMBER;
            EW_G:  ew_lamp_o = LAMP_GREEN;
            EW_A:  ew_lamp_o = LAMP_AMBER;
            WALK:  ped_walk_o = 1'b1;
            FLASH: begin
                ns_lamp_o = flash_q ? LAMP_AMBER : LAMP_OFF;
                ew_lamp_o = flash_q ? LAMP_AMBER : LAMP_OFF;
            end
            default: begin
                // AR_NS, AR_EW and any stray encoding show both heads red.
                ns_lamp_o = LAMP_RED;
                ew_lamp_o = LAMP_RED;
            end
        endcase
    end

    assign ped_pending_o = pending_q;

endmodule

// File: tb/tb_traffic_junction.sv
// -----------------------------------------------------------------------------
// tb_traffic_junction
//
// Directed bench for traffic_junction with default parameters. Each task
// drives one scenario and compares the lamp/walk/pending outputs against
// hand-computed values. Cycle indices in the comments count clock edges after
// reset release: index 0 is the cycle immediately after release.
//
// Default cycle map (period 30):
//   0-1 AR_NS, 2-3 NS_RA, 4-11 NS_G, 12-14 NS_A,
//   15-16 AR_EW, 17-18 EW_RA, 19-26 EW_G, 27-29 EW_A
// -----------------------------------------------------------------------------
module tb_traffic_junction;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] RA  = 3'b110;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] A   = 3'b010;
    localparam logic [2:0] OFF = 3'b000;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       ped_req_i = 1'b0;
    logic       fault_i = 1'b0;
    logic [2:0] ns_lamp_o;
    logic [2:0] ew_lamp_o;
    logic       ped_walk_o;
    logic       ped_pending_o;

    int errors = 0;
    int checks = 0;

    traffic_junction dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .ped_req_i     (ped_req_i),
        .fault_i       (fault_i),
        .ns_lamp_o     (ns_lamp_o),
        .ew_lamp_o     (ew_lamp_o),
        .ped_walk_o    (ped_walk_o),
        .ped_pending_o (ped_pending_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Reset across one edge; on return the design is at cycle index 0.
    task automatic do_reset();
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        reset_i = 1'b1;
        #2;
        checks++;
        if ({ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o} !== {R, R, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: ns=%b ew=%b walk=%b pend=%b required ns=100 ew=100 walk=0 pend=0",
                     ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o);
        end
        ped_req_i = 1'b1;
        ticks(2);
        checks++;
        if ({ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o} !== {R, R, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_held: ns=%b ew=%b walk=%b pend=%b required ns=100 ew=100 walk=0 pend=0",
                     ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o);
        end
        ped_req_i = 1'b0;
        reset_i = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_idle_cycle();
        logic [2:0] exp_ns;
        logic [2:0] exp_ew;
        int         ph;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            ph = i % 30;
            if (ph < 2)       begin exp_ns = R;  exp_ew = R;  end
            else if (ph < 4)  begin exp_ns = RA; exp_ew = R;  end
            else if (ph < 12) begin exp_ns = G;  exp_ew = R;  end
            else if (ph < 15) begin exp_ns = A;  exp_ew = R;  end
            else if (ph < 17) begin exp_ns = R;  exp_ew = R;  end
            else if (ph < 19) begin exp_ns = R;  exp_ew = RA; end
            else if (ph < 27) begin exp_ns = R;  exp_ew = G;  end
            else              begin exp_ns = R;  exp_ew = A;  end
            checks++;
            if ({ns_lamp_o, ew_lamp_o, ped_walk_o} !== {exp_ns, exp_ew, 1'b0}) begin
                errors++;
                $display("FAIL idle_cycle[%0d]: ns=%b ew=%b walk=%b required ns=%b ew=%b walk=0",
                         i, ns_lamp_o, ew_lamp_o, ped_walk_o, exp_ns, exp_ew);
            end
            checks++;
            if (ns_lamp_o[2] === 1'b0 && ew_lamp_o[2] === 1'b0) begin
                errors++;
                $display("FAIL idle_both_open[%0d]: ns=%b ew=%b required at least one head red",
                         i, ns_lamp_o, ew_lamp_o);
            end
            ticks(1);
        end
        $display("test_idle_cycle done");
    endtask

    task automatic test_ped_walk();
        do_reset();
        ticks(5);                       // index 5, NS_G
        ped_req_i = 1'b1;
        ticks(1);                       // index 6
        ped_req_i = 1'b0;
        checks++;
        if (ped_pending_o !== 1'b1) begin
            errors++;
            $display("FAIL ped_latch: pending=%b required 1", ped_pending_o);
        end
        ticks(8);                       // index 14, last NS_A cycle
        checks++;
        if ({ns_lamp_o, ped_pending_o} !== {A, 1'b1}) begin
            errors++;
            $display("FAIL ped_before_walk: ns=%b pend=%b required ns=010 pend=1", ns_lamp_o, ped_pending_o);
        end
        for (int i = 0; i < 6; i++) begin
            ticks(1);                   // index 15..20, WALK
            checks++;
            if ({ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o} !== {R, R, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL ped_walk[%0d]: ns=%b ew=%b walk=%b pend=%b required ns=100 ew=100 walk=1 pend=0",
                         i, ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o);
            end
            // A request during WALK must be ignored.
            ped_req_i = (i == 2);
        end
        ped_req_i = 1'b0;
        ticks(1);                       // index 21, AR_EW
        checks++;
        if ({ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o} !== {R, R, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ped_after_walk: ns=%b ew=%b walk=%b pend=%b required ns=100 ew=100 walk=0 pend=0",
                     ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o);
        end
        ticks(2);                       // index 23, EW_RA
        checks++;
        if ({ns_lamp_o, ew_lamp_o} !== {R, RA}) begin
            errors++;
            $display("FAIL ped_then_ew_ra: ns=%b ew=%b required ns=100 ew=110", ns_lamp_o, ew_lamp_o);
        end
        $display("test_ped_walk done");
    endtask

    task automatic test_ped_on_expiry();
        do_reset();
        ticks(14);                      // index 14, NS_A counter at zero
        ped_req_i = 1'b1;
        ticks(1);                       // index 15
        ped_req_i = 1'b0;
        checks++;
        if ({ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o} !== {R, R, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL expiry_no_walk: ns=%b ew=%b walk=%b pend=%b required ns=100 ew=100 walk=0 pend=1",
                     ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o);
        end
        ticks(2);                       // index 17, EW_RA
        checks++;
        if ({ns_lamp_o, ew_lamp_o} !== {R, RA}) begin
            errors++;
            $display("FAIL expiry_ew_ra: ns=%b ew=%b required ns=100 ew=110", ns_lamp_o, ew_lamp_o);
        end
        ticks(13);                      // index 30, WALK after EW_A
        checks++;
        if ({ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o} !== {R, R, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL expiry_walk_start: ns=%b ew=%b walk=%b pend=%b required ns=100 ew=100 walk=1 pend=0",
                     ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o);
        end
        ticks(5);                       // index 35, last WALK cycle
        checks++;
        if (ped_walk_o !== 1'b1) begin
            errors++;
            $display("FAIL expiry_walk_end: walk=%b required 1", ped_walk_o);
        end
        ticks(1);                       // index 36, AR_NS
        checks++;
        if ({ns_lamp_o, ew_lamp_o, ped_walk_o} !== {R, R, 1'b0}) begin
            errors++;
            $display("FAIL expiry_ar_ns: ns=%b ew=%b walk=%b required ns=100 ew=100 walk=0",
                     ns_lamp_o, ew_lamp_o, ped_walk_o);
        end
        ticks(2);                       // index 38, NS_RA
        checks++;
        if ({ns_lamp_o, ew_lamp_o} !== {RA, R}) begin
            errors++;
            $display("FAIL expiry_ns_ra: ns=%b ew=%b required ns=110 ew=100", ns_lamp_o, ew_lamp_o);
        end
        $display("test_ped_on_expiry done");
    endtask

    task automatic test_fault_flash();
        logic [2:0] exp_l;
        do_reset();
        ticks(20);                      // index 20, EW_G
        fault_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            ticks(1);                   // index 20+k
            exp_l = (((k - 1) / 4) % 2 == 0) ? A : OFF;
            checks++;
            if ({ns_lamp_o, ew_lamp_o, ped_walk_o} !== {exp_l, exp_l, 1'b0}) begin
                errors++;
                $display("FAIL flash[%0d]: ns=%b ew=%b walk=%b required ns=%b ew=%b walk=0",
                         k, ns_lamp_o, ew_lamp_o, ped_walk_o, exp_l, exp_l);
            end
        end
        fault_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ticks(1);
            checks++;
            if ({ns_lamp_o, ew_lamp_o} !== {R, R}) begin
                errors++;
                $display("FAIL flash_exit_ar[%0d]: ns=%b ew=%b required ns=100 ew=100",
                         k, ns_lamp_o, ew_lamp_o);
            end
        end
        ticks(1);
        checks++;
        if ({ns_lamp_o, ew_lamp_o} !== {RA, R}) begin
            errors++;
            $display("FAIL flash_exit_ns_ra: ns=%b ew=%b required ns=110 ew=100", ns_lamp_o, ew_lamp_o);
        end
        $display("test_fault_flash done");
    endtask

    task automatic test_fault_clears_pending();
        do_reset();
        ticks(5);                       // index 5, NS_G
        ped_req_i = 1'b1;
        ticks(1);                       // index 6
        ped_req_i = 1'b0;
        fault_i = 1'b1;
        ticks(1);                       // index 7, FLASH
        checks++;
        if ({ns_lamp_o, ped_pending_o} !== {A, 1'b0}) begin
            errors++;
            $display("FAIL fault_pend_clear: ns=%b pend=%b required ns=010 pend=0", ns_lamp_o, ped_pending_o);
        end
        ped_req_i = 1'b1;               // ignored while flashing
        ticks(1);                       // index 8
        ped_req_i = 1'b0;
        fault_i = 1'b0;
        checks++;
        if (ped_pending_o !== 1'b0) begin
            errors++;
            $display("FAIL fault_req_ignored: pend=%b required 0", ped_pending_o);
        end
        ticks(1);                       // AR_NS restart (relative index 0)
        checks++;
        if ({ns_lamp_o, ew_lamp_o} !== {R, R}) begin
            errors++;
            $display("FAIL fault_exit: ns=%b ew=%b required ns=100 ew=100", ns_lamp_o, ew_lamp_o);
        end
        ticks(15);                      // relative 15, AR_EW without WALK
        checks++;
        if ({ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o} !== {R, R, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fault_no_walk: ns=%b ew=%b walk=%b pend=%b required ns=100 ew=100 walk=0 pend=0",
                     ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o);
        end
        ticks(2);                       // relative 17, EW_RA
        checks++;
        if ({ns_lamp_o, ew_lamp_o} !== {R, RA}) begin
            errors++;
            $display("FAIL fault_ew_ra: ns=%b ew=%b required ns=100 ew=110", ns_lamp_o, ew_lamp_o);
        end
        $display("test_fault_clears_pending done");
    endtask

    task automatic test_async_reset_walk();
        do_reset();
        ticks(5);
        ped_req_i = 1'b1;
        ticks(1);
        ped_req_i = 1'b0;
        ticks(11);                      // index 17, inside WALK
        checks++;
        if (ped_walk_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_in_walk: walk=%b required 1", ped_walk_o);
        end
        #2;
        reset_i = 1'b1;
        #1;
        checks++;
        if ({ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o} !== {R, R, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL areset_immediate: ns=%b ew=%b walk=%b pend=%b required ns=100 ew=100 walk=0 pend=0",
                     ns_lamp_o, ew_lamp_o, ped_walk_o, ped_pending_o);
        end
        #1;
        reset_i = 1'b0;                 // released before the next edge: index 0
        ticks(1);                       // index 1, AR_NS
        checks++;
        if ({ns_lamp_o, ew_lamp_o} !== {R, R}) begin
            errors++;
            $display("FAIL areset_ar_ns: ns=%b ew=%b required ns=100 ew=100", ns_lamp_o, ew_lamp_o);
        end
        ticks(1);                       // index 2, NS_RA
        checks++;
        if ({ns_lamp_o, ew_lamp_o} !== {RA, R}) begin
            errors++;
            $display("FAIL areset_ns_ra: ns=%b ew=%b required ns=110 ew=100", ns_lamp_o, ew_lamp_o);
        end
        $display("test_async_reset_walk done");
    endtask

    initial begin
        test_reset();
        test_idle_cycle();
        test_ped_walk();
        test_ped_on_expiry();
        test_fault_flash();
        test_fault_clears_pending();
        test_async_reset_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
